rom_dot_seq: RTL and testbench

- Sequencer directly upstream of the 4x4 multiplication lookup ROM (`rom`, ports n1/n2/result, with result = n1*n2).
- Accepts a stream of 4-bit operand pairs over a valid/ready handshake, drives the ROM address ports from registers, and accumulates the returned 8-bit products.
- After N pairs it presents the dot-product sum over a valid/ready output handshake.
- The ROM instance is external; this block only drives its n1/n2 inputs and consumes its result.

---
 rtl/rom_dot_seq.sv | 125 ++++++++++++
 tb/tb_rom_dot_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dot_seq.sv
// rom_dot_seq: operand-pair sequencer feeding an external 4x4 multiply ROM.
//
// Accepts 4-bit operand pairs over a valid/ready handshake, registers them
// onto the ROM address ports, accumulates the ROM's 8-bit products, and
// after N pairs offers the dot-product sum over a valid/ready handshake.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    pair can be accepted this cycle
//   a, b        operands
//   rom_n1/n2   registered ROM address drive
//   rom_result  ROM product (combinational from rom_n1/rom_n2)
//   out_valid   acc_out holds a completed sum
//   out_ready   downstream takes the sum
//   acc_out     accumulated sum (mod 2^ACC_W)
//   ovf         sticky wrap flag for the current sum
module rom_dot_seq #(
  parameter int N     = 4,
  parameter int ACC_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [3:0]       rom_n1,
  output logic [3:0]       rom_n2,
  input  logic [7:0]       rom_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // The add is done wide enough to hold both the full product and one
  // carry bit, so any bit above ACC_W marks a wrap even when ACC_W < 8.
  localparam int EXT_W = ((ACC_W > 8) ? ACC_W : 8) + 1;

  state_e             state_q, state_d;
  logic [3:0]         n1_q, n1_d;
  logic [3:0]         n2_q, n2_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [EXT_W-1:0]   sum_ext;
  logic               wrap;

  assign sum_ext = EXT_W'(acc_q) + EXT_W'(rom_result);
  assign wrap    = |sum_ext[EXT_W-1:ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCEPT;
      n1_q    <= '0;
      n2_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          n1_d    = a;
          n2_d    = b;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // ROM output reflects the address registered on the previous edge.
        acc_d = sum_ext[ACC_W-1:0];
        ovf_d = ovf_q | wrap;
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  assign in_ready  = (state_q == ST_ACCEPT);
  assign out_valid = (state_q == ST_DONE);
  assign rom_n1    = n1_q;
  assign rom_n2    = n2_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rom_dot_seq.sv
// Bench for rom_dot_seq: default instance, an ACC_W=8 instance sharing its
// stimulus, and an N=1 instance driven by its own streaming sequence.
module tb_rom_dot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] a, b;

  logic       in_ready, out_valid, ovf;
  logic [3:0] rom_n1, rom_n2;
  logic [7:0] rom_result;
  logic [9:0] acc_out;

  logic       in_ready8, out_valid8, ovf8;
  logic [3:0] rom_n1_8, rom_n2_8;
  logic [7:0] rom_result8;
  logic [7:0] acc_out8;

  logic       in_valid1, out_ready1;
  logic [3:0] a1, b1;
  logic       in_ready1, out_valid1, ovf1;
  logic [3:0] rom_n1_1, rom_n2_1;
  logic [7:0] rom_result1;
  logic [9:0] acc_out1;

  always #5 clk = ~clk;

  // External ROM behaviour: product of the two address nibbles.
  assign rom_result  = 8'(rom_n1)   * 8'(rom_n2);
  assign rom_result8 = 8'(rom_n1_8) * 8'(rom_n2_8);
  assign rom_result1 = 8'(rom_n1_1) * 8'(rom_n2_1);

  rom_dot_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rom_n1(rom_n1), .rom_n2(rom_n2), .rom_result(rom_result),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  rom_dot_seq #(.N(4), .ACC_W(8), .CNT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .rom_n1(rom_n1_8), .rom_n2(rom_n2_8), .rom_result(rom_result8),
    .out_valid(out_valid8), .out_ready(out_ready), .acc_out(acc_out8), .ovf(ovf8)
  );

  rom_dot_seq #(.N(1), .ACC_W(10), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .rom_n1(rom_n1_1), .rom_n2(rom_n2_1), .rom_result(rom_result1),
    .out_valid(out_valid1), .out_ready(out_ready1), .acc_out(acc_out1), .ovf(ovf1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int part  = 0;       // running sum of products for the sum in progress
  logic [3:0] last_a, last_b;

  typedef struct {
    logic [15:0] av;    // pair i operand a in bits [4i+3:4i]
    logic [15:0] bv;
    int          gap1;  // idle cycles before pair 1
    int          hold;  // cycles of out_ready=0 after out_valid
    bit          conc;  // offer a pair while waiting in DONE
    int          exp_acc;
    bit          exp_ovf;
    int          exp_acc8;
    bit          exp_ovf8;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [3:0] pa, input logic [3:0] pb, input int gap);
    int cyc;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    if (gap > 0) chk("gap_hold", 32'(acc_out), 32'(part % 1024));
    in_valid = 1'b1;
    a = pa;
    b = pb;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      step();
      cyc++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("rom_n1", 32'(rom_n1), 32'(pa));
    chk("rom_n2", 32'(rom_n2), 32'(pb));
    chk("in_ready_lookup", 32'(in_ready), 0);
    last_a = pa;
    last_b = pb;
    part += int'(pa) * int'(pb);
    $display("pair a=%0d b=%0d accepted, running sum %0d", pa, pb, part);
  endtask

  task automatic get_result(input int ea, input bit eo, input int ea8, input bit eo8,
                            input int hold, input bit conc);
    int cyc;
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("out_valid", 32'(out_valid), 1);
    chk("out_latency", 32'(cyc), 1);
    chk("acc_out", 32'(acc_out), 32'(ea));
    chk("ovf", 32'(ovf), 32'(eo));
    chk("acc_out8", 32'(acc_out8), 32'(ea8));
    chk("ovf8", 32'(ovf8), 32'(eo8));
    if (conc) begin
      in_valid = 1'b1;
      a = 4'd1;
      b = 4'd1;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_acc", 32'(acc_out), 32'(ea));
      chk("hold_ovf", 32'(ovf), 32'(eo));
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_rom_n1", 32'(rom_n1), 32'(last_a));
      chk("hold_rom_n2", 32'(rom_n2), 32'(last_b));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_out_valid", 32'(out_valid), 0);
    chk("post_acc", 32'(acc_out), 0);
    chk("post_ovf", 32'(ovf), 0);
    chk("post_acc8", 32'(acc_out8), 0);
    chk("post_ovf8", 32'(ovf8), 0);
    $display("sum taken: acc=%0d ovf=%0d acc8=%0d ovf8=%0d after %0d hold cycles",
             ea, eo, ea8, eo8, hold);
    part = 0;
  endtask

  initial begin
    int first_v, last_v, n_v;
    vecs[0] = '{16'h0F23, 16'h9F75, 0, 0, 1'b0, 254, 1'b0, 254, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 0, 1'b0, 900, 1'b0, 132, 1'b1};
    vecs[2] = '{16'h1111, 16'h1111, 0, 0, 1'b0,   4, 1'b0,   4, 1'b0};
    vecs[3] = '{16'h7531, 16'h8642, 6, 0, 1'b0, 100, 1'b0, 100, 1'b0};
    vecs[4] = '{16'h2222, 16'h3333, 0, 5, 1'b1,  24, 1'b0,  24, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    #2;
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rom_n1", 32'(rom_n1), 0);
    chk("rst_ovf", 32'(ovf), 0);
    #20 rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 1);

    // Table-driven sums.
    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < 4; p++)
        send_pair(vecs[v].av[4*p +: 4], vecs[v].bv[4*p +: 4], (p == 1) ? vecs[v].gap1 : 0);
      get_result(vecs[v].exp_acc, vecs[v].exp_ovf, vecs[v].exp_acc8, vecs[v].exp_ovf8,
                 vecs[v].hold, vecs[v].conc);
    end

    // Reset in the middle of a sum, off the clock edge.
    send_pair(4'd5, 4'd5, 0);
    send_pair(4'd6, 4'd6, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_acc", 32'(acc_out), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_rom_n1", 32'(rom_n1), 0);
    chk("midrst_rom_n2", 32'(rom_n2), 0);
    $display("reset asserted mid-sum, partial %0d discarded", part);
    part = 0;
    #10 rst_n = 1'b1;
    step();
    for (int p = 0; p < 4; p++) send_pair(4'd2, 4'd2, 0);
    get_result(16, 1'b0, 16, 1'b0, 0, 1'b0);

    // Randomized sums against an arithmetic model.
    for (int s = 0; s < 15; s++) begin
      logic [3:0] ra[4];
      logic [3:0] rb[4];
      int tot;
      tot = 0;
      for (int p = 0; p < 4; p++) begin
        ra[p] = 4'($urandom_range(0, 15));
        rb[p] = 4'($urandom_range(0, 15));
        tot += int'(ra[p]) * int'(rb[p]);
      end
      for (int p = 0; p < 4; p++) send_pair(ra[p], rb[p], int'($urandom_range(0, 2)));
      get_result(tot % 1024, tot >= 1024, tot % 256, tot >= 256,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // N=1 instance: continuous stream of (9,7) with out_ready held high.
    a1 = 4'd9; b1 = 4'd7; in_valid1 = 1'b1;
    first_v = -1; last_v = -1; n_v = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (out_valid1) begin
        chk("n1_acc", 32'(acc_out1), 63);
        if (first_v < 0) first_v = i;
        else chk("n1_period", 32'(i - last_v), 3);
        last_v = i;
        n_v++;
        $display("N=1 result acc=%0d at cycle %0d", acc_out1, i);
      end
    end
    in_valid1 = 1'b0;
    chk("n1_first_latency", 32'(first_v), 2);
    chk("n1_count", 32'(n_v), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
